// File: rtl/mul8_pkg.sv
// Shared types for the mul8 arbiter slice: operand/product widths, FSM states
// and the upper bound on requester count.
package mul8_pkg;

    localparam int unsigned NREQ_MAX = 8;

    typedef logic [7:0]  operand_t;
    typedef logic [15:0] product_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mul8_share_arbiter_if.sv
// Request/response bus between the multiplier clients and the shared arbiter.
// master = client side, slave = arbiter side.
interface mul8_share_arbiter_if #(
    parameter int unsigned NREQ = 4
);
    import mul8_pkg::*;

    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    operand_t [NREQ-1:0]  req_a;
    operand_t [NREQ-1:0]  req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    product_t             rsp_product;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product
    );

endinterface

// File: rtl/mul8_rr_grant.sv
// Combinational round-robin picker: first asserted req scanning from ptr upward, mod NREQ.
module mul8_rr_grant #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((32'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/wallaceTreeMultiplier8Bit.sv
// 8x8 unsigned multiplier datapath shared by the arbiter; full 16-bit product.
module wallaceTreeMultiplier8Bit (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] result
);

    assign result = 16'(a) * 16'(b);

endmodule

// File: rtl/mul8_share_arbiter.sv
// Round-robin sharing of one 8x8 multiplier among NREQ requesters with a single response channel.
// Define MUL8_PIPE_EN to register the granted operands ahead of the multiplier (adds the MUL state).
module mul8_share_arbiter
    import mul8_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul8_share_arbiter_if.slave  bus,
    output logic                 busy,
    output logic [15:0]          txn_count
);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    product_t        rsp_product_q, rsp_product_d;
    logic [15:0]     txn_count_q, txn_count_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic            any_req;
    logic            rsp_hs;
    logic            grant_en;
    logic            xfer;
    operand_t        mul_a, mul_b;
    product_t        mul_result;

    mul8_rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_grant (
        .req    (bus.req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .any    (any_req)
    );

    wallaceTreeMultiplier8Bit u_mul (
        .a      (mul_a),
        .b      (mul_b),
        .result (mul_result)
    );

    // A new grant may overlap the response handshake so RESP can chain transfers back to back.
    assign rsp_hs        = (state_q == RESP) && bus.rsp_ready;
    assign grant_en      = (state_q == IDLE) || rsp_hs;
    assign xfer          = grant_en && any_req;
    assign bus.req_ready = grant_en ? gnt : '0;

`ifdef MUL8_PIPE_EN
    operand_t       op_a_q, op_a_d;
    operand_t       op_b_q, op_b_d;
    logic [IDW-1:0] id_q, id_d;

    assign mul_a = op_a_q;
    assign mul_b = op_b_q;
`else
    assign mul_a = bus.req_a[gnt_id];
    assign mul_b = bus.req_b[gnt_id];
`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        txn_count_d   = txn_count_q + 16'(rsp_hs);
`ifdef MUL8_PIPE_EN
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        id_d          = id_q;
`endif

        if (rsp_hs) begin
            state_d = IDLE;
        end

`ifdef MUL8_PIPE_EN
        if (state_q == MUL) begin
            rsp_product_d = mul_result;
            rsp_id_d      = id_q;
            state_d       = RESP;
        end
`endif

        if (xfer) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
`ifdef MUL8_PIPE_EN
            op_a_d  = bus.req_a[gnt_id];
            op_b_d  = bus.req_b[gnt_id];
            id_d    = gnt_id;
            state_d = MUL;
`else
            rsp_product_d = mul_result;
            rsp_id_d      = gnt_id;
            state_d       = RESP;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            txn_count_q   <= '0;
`ifdef MUL8_PIPE_EN
            op_a_q        <= '0;
            op_b_q        <= '0;
            id_q          <= '0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            txn_count_q   <= txn_count_d;
`ifdef MUL8_PIPE_EN
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            id_q          <= id_d;
`endif
        end
    end

    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_product = rsp_product_q;
    assign busy            = (state_q != IDLE);
    assign txn_count       = txn_count_q;

endmodule

// File: tb/tb_mul8_share_arbiter.sv
// Directed bench for mul8_share_arbiter: vector table of single transactions plus
// hand-written round-robin, back-pressure, reset, skip and counter-wrap sequences.
module tb_mul8_share_arbiter;

    localparam int unsigned NREQ = 4;
`ifdef MUL8_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] txn_count;
    logic [15:0] exp_count;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[6];

    mul8_share_arbiter_if #(.NREQ(NREQ)) bus ();

    mul8_share_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .txn_count (txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_count = '0;
    endtask

    task automatic wait_rsp(input string name, input int budget);
        int waited;
        waited = 0;
        while (!bus.rsp_valid && waited < budget) begin
            tick();
            waited++;
        end
        check({name, " rsp_valid"}, 32'(bus.rsp_valid), 1);
    endtask

    // One isolated transaction from IDLE, checking latency, payload and counter.
    task automatic run_vec(input vec_t v);
        bus.rsp_ready       = 1'b0;
        bus.req_valid       = '0;
        bus.req_valid[v.id] = 1'b1;
        bus.req_a[v.id]     = v.a;
        bus.req_b[v.id]     = v.b;
        #1;
        check("vec req_ready", 32'(bus.req_ready), 32'(1) << v.id);
        tick();
        bus.req_valid = '0;
        check("vec busy", 32'(busy), 1);
        for (int c = 1; c < LAT; c++) begin
            check("vec early rsp_valid", 32'(bus.rsp_valid), 0);
            tick();
        end
        check("vec rsp_valid", 32'(bus.rsp_valid), 1);
        check("vec rsp_product", 32'(bus.rsp_product), 32'(v.prod));
        check("vec rsp_id", 32'(bus.rsp_id), 32'(v.id));
        check("vec txn_count pre", 32'(txn_count), 32'(exp_count));
        bus.rsp_ready = 1'b1;
        tick();
        exp_count++;
        bus.rsp_ready = 1'b0;
        check("vec txn_count post", 32'(txn_count), 32'(exp_count));
        check("vec idle", 32'(busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_id[5];
        int rr_prod[5];
        int got, cyc, first_cyc, last_cyc, seen, done;

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        exp_count     = '0;

        vecs[0] = '{2, 8'd255, 8'd255, 16'hFE01};
        vecs[1] = '{0, 8'd0,   8'd255, 16'h0000};
        vecs[2] = '{3, 8'd1,   8'h80,  16'h0080};
        vecs[3] = '{1, 8'd7,   8'd9,   16'd63};
        vecs[4] = '{2, 8'd16,  8'd16,  16'd256};
        vecs[5] = '{3, 8'd200, 8'd100, 16'd20000};

        rr_id   = '{0, 1, 2, 3, 0};
        rr_prod = '{3, 6, 9, 12, 3};

        // Reset state and idle with no requests
        reset_dut();
        check("reset req_ready", 32'(bus.req_ready), 0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 0);
        check("reset rsp_id", 32'(bus.rsp_id), 0);
        check("reset rsp_product", 32'(bus.rsp_product), 0);
        check("reset busy", 32'(busy), 0);
        check("reset txn_count", 32'(txn_count), 0);
        repeat (3) tick();
        check("idle busy", 32'(busy), 0);
        check("idle req_ready", 32'(bus.req_ready), 0);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Round-robin with all requesters valid and rsp_ready high
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid[i] = 1'b1;
            bus.req_a[i]     = 8'(i + 1);
            bus.req_b[i]     = 8'd3;
        end
        bus.rsp_ready = 1'b1;
        got = 0; cyc = 0; first_cyc = 0; last_cyc = 0;
        while (got < 5 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.rsp_valid) begin
                check("rr rsp_id", 32'(bus.rsp_id), 32'(rr_id[got]));
                check("rr rsp_product", 32'(bus.rsp_product), 32'(rr_prod[got]));
                if (got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
        end
        check("rr responses", 32'(got), 5);
        check("rr throughput span", 32'(last_cyc - first_cyc), 32'(4 * LAT));

        // Back-pressure with requester 1 pending
        reset_dut();
        bus.req_valid[0] = 1'b1;
        bus.req_a[0]     = 8'd5;
        bus.req_b[0]     = 8'd6;
        tick();
        bus.req_valid    = '0;
        bus.req_valid[1] = 1'b1;
        bus.req_a[1]     = 8'd4;
        bus.req_b[1]     = 8'd11;
        wait_rsp("bp first", 5);
        for (int i = 0; i < 5; i++) begin
            check("bp stall rsp_product", 32'(bus.rsp_product), 30);
            check("bp stall rsp_id", 32'(bus.rsp_id), 0);
            check("bp stall req_ready", 32'(bus.req_ready), 0);
            check("bp stall rsp_valid", 32'(bus.rsp_valid), 1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp grant on release", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        check("bp txn_count 1", 32'(txn_count), 1);
        wait_rsp("bp second", 5);
        check("bp second product", 32'(bus.rsp_product), 44);
        check("bp second id", 32'(bus.rsp_id), 1);
        tick();
        check("bp txn_count 2", 32'(txn_count), 2);

        // Reset mid-flight discards the transaction
        reset_dut();
        bus.req_valid[3] = 1'b1;
        bus.req_a[3]     = 8'd200;
        bus.req_b[3]     = 8'd100;
        tick();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rstmid rsp_valid", 32'(bus.rsp_valid), 0);
        check("rstmid rsp_product", 32'(bus.rsp_product), 0);
        check("rstmid rsp_id", 32'(bus.rsp_id), 0);
        check("rstmid busy", 32'(busy), 0);
        check("rstmid txn_count", 32'(txn_count), 0);
        check("rstmid req_ready", 32'(bus.req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        check("rstmid no response", 32'(seen), 0);
        exp_count = '0;
        run_vec('{1, 8'd7, 8'd9, 16'd63});
        check("rstmid txn_count", 32'(txn_count), 1);

        // Requester 0 drops valid before its turn; requester 1 is served
        reset_dut();
        bus.req_valid[2] = 1'b1;
        bus.req_a[2]     = 8'd2;
        bus.req_b[2]     = 8'd2;
        tick();
        bus.req_valid    = '0;
        bus.req_valid[0] = 1'b1;
        bus.req_a[0]     = 8'd9;
        bus.req_b[0]     = 8'd9;
        bus.req_valid[1] = 1'b1;
        bus.req_a[1]     = 8'd12;
        bus.req_b[1]     = 8'd12;
        wait_rsp("skip first", 5);
        check("skip first product", 32'(bus.rsp_product), 4);
        check("skip first id", 32'(bus.rsp_id), 2);
        tick();
        bus.req_valid[0] = 1'b0;
        bus.rsp_ready    = 1'b1;
        #1;
        check("skip grant", 32'(bus.req_ready), 32'b0010);
        tick();
        bus.req_valid = '0;
        wait_rsp("skip second", 5);
        check("skip second product", 32'(bus.rsp_product), 144);
        check("skip second id", 32'(bus.rsp_id), 1);
        tick();

        // 65536 completions wrap the counter back to zero
        reset_dut();
        bus.req_valid[1] = 1'b1;
        bus.req_a[1]     = 8'd1;
        bus.req_b[1]     = 8'd1;
        bus.rsp_ready    = 1'b1;
        done = 0;
        cyc  = 0;
        while (done < 65536 && cyc < 65536 * LAT + 16) begin
            if (bus.rsp_valid) begin
                done++;
                if (done == 65536) begin
                    bus.req_valid = '0;
                    check("wrap count before", 32'(txn_count), 32'hFFFF);
                end
            end
            tick();
            cyc++;
        end
        check("wrap completions", 32'(done), 65536);
        check("wrap txn_count", 32'(txn_count), 0);
        check("wrap idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul8_share_arbiter.md
# mul8_share_arbiter

Round-robin arbiter and sequencer that shares one `wallaceTreeMultiplier8Bit` instance between `NREQ` requesters. Requesters present 8-bit unsigned operand pairs over valid/ready. The block grants one requester at a time and drives the multiplier. It returns the 16-bit product with the requester ID over a single valid/ready response channel. It sits between the multiplier datapath and its client blocks, and is the only place the multiplier is instantiated.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: requester ID width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in `NREQ`: per-requester operand valid.
- `req_ready` out `NREQ`: per-requester accept; one-hot or zero.
- `req_a` in `NREQ`×8: per-requester operand a, unsigned.
- `req_b` in `NREQ`×8: per-requester operand b, unsigned.
- `rsp_valid` out 1: product available.
- `rsp_ready` in 1: consumer accepts product.
- `rsp_id` out `IDW`: requester index of the product.
- `rsp_product` out 16: a×b.
- `busy` out 1: a transaction is in flight (state ≠ IDLE).
- `txn_count` out 16: completed responses; wraps 0xFFFF→0x0000.

## Operation
- FSM states: IDLE, MUL (only when `MUL8_PIPE_EN` is defined), RESP.
- **Grant rule**
  - Priority pointer `ptr`, reset 0.
  - The winner is the first `i` with `req_valid[i]`, scanning `ptr`, `ptr+1`, … mod `NREQ`.
  - Grant is allowed only in IDLE, or in RESP in the same cycle that `rsp_valid && rsp_ready`.
  - `req_ready[winner]` is asserted combinationally in that cycle. It may depend on `req_valid`.
  - A transfer occurs on `req_valid[i] && req_ready[i]`. On transfer, `ptr` ← `winner+1` mod `NREQ`.
- **Without `MUL8_PIPE_EN`**
  - The muxed operands of the winner feed the multiplier directly.
  - On transfer: product → `rsp_product`, winner → `rsp_id`, go to RESP.
- **With `MUL8_PIPE_EN`**
  - On transfer: operands → `op_a`/`op_b` registers, winner → `id_q`, go to MUL.
  - In MUL: product of `op_a`/`op_b` → `rsp_product`, go to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - `rsp_product` and `rsp_id` stay stable until the handshake.
  - On `rsp_ready`: `txn_count`++.
  - Next state: IDLE if no grant in that cycle; otherwise the post-transfer state above.
- **Arithmetic:** full 16-bit unsigned product, no truncation. 255×255 = 0xFE01.
- **Boundary conditions**
  - No `req_valid` in IDLE: stay IDLE, all `req_ready` = 0.
  - A requester may drop `req_valid` before being granted; it is simply skipped.
  - `rsp_ready` held low stalls indefinitely. All `req_ready` stay 0 meanwhile.
  - `rst_n` low mid-transaction: the in-flight product is discarded, with no response.
  - `txn_count` wraps silently.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_product` = 0.
  - `busy` = 0, `txn_count` = 0, `ptr` = 0, state = IDLE.
- Latency from transfer cycle T to `rsp_valid`:
  - T+1 without `MUL8_PIPE_EN`.
  - T+2 with it.
- Throughput with `rsp_ready` tied high:
  - 1 product/cycle without `MUL8_PIPE_EN` (back-to-back grants in RESP).
  - 1 per 2 cycles with it.
- `txn_count` updates on the clock edge that completes the response handshake.
- Combinational paths:
  - Without the macro: `req_a`/`req_b` → multiplier → `rsp_product` D input (single-cycle path).
  - Always: `req_valid` → `req_ready`.

## Configuration
- Macro: `MUL8_PIPE_EN`.
- Defined: adds the operand register stage and the MUL state.
  - Cuts the operand-mux → multiplier path.
  - Latency 2, throughput ½.
- Undefined: no operand registers, no MUL state.
  - Latency 1, throughput 1.
- Grant rule, response channel and `txn_count` are identical in both builds.

## Structure
- Package `mul8_pkg`:
  - `operand_t` (logic [7:0]).
  - `product_t` (logic [15:0]).
  - FSM state enum `arb_state_e` {IDLE, MUL, RESP}.
  - `NREQ_MAX` = 8.
- Sub-module `mul8_rr_grant`:
  - Parameter `NREQ`.
  - Inputs: `req` vector, `ptr`.
  - Outputs: one-hot `gnt`, `gnt_id`, `any`.
  - Purely combinational; `ptr` lives in the parent.
- The parent holds the FSM, the registers, `txn_count` and one `wallaceTreeMultiplier8Bit` instance (ports `a`, `b`, `result`).

## Test plan
- **Single request.** Reset, then requester 2 sends a=255, b=255.
  - `rsp_valid` at T+1 (T+2 with the macro).
  - `rsp_product` = 0xFE01, `rsp_id` = 2, `txn_count` = 1.
- **Round-robin fairness.** All 4 requesters continuously valid, a=i+1, b=3, `rsp_ready` = 1.
  - Grant order 0,1,2,3,0.
  - Products 3, 6, 9, 12, 3.
- **Back-pressure.** `rsp_ready` = 0 for 5 cycles after `rsp_valid`, with requester 1 pending.
  - `rsp_product`/`rsp_id` stable, `req_ready` = 0 throughout.
  - Requester 1 granted in the cycle `rsp_ready` rises.
- **Reset mid-flight.** Assert `rst_n` low the cycle after a transfer of 200×100.
  - All outputs return to reset values; no response is ever issued.
  - Next request (7×9) returns 63 with `txn_count` = 1.
- **Skip and counter wrap.**
  - Requester 0 drops `req_valid` before its grant: requester 1 is served instead.
  - Force 65536 completions: `txn_count` reads 0.
- **Zero operands.** a=0, b=255 → `rsp_product` = 0; a=1, b=0x80 → 0x0080.
